// File: rtl/inference_sequencer_if.sv
// Pixel-stream and result handshakes between the image source/consumer and the
// inference sequencer.
interface inference_sequencer_if;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       result_valid;
  logic [3:0] result_digit;
  logic       result_ready;

  modport master (
    output pix_valid, pix_data, result_ready,
    input  pix_ready, result_valid, result_digit
  );

  modport slave (
    input  pix_valid, pix_data, result_ready,
    output pix_ready, result_valid, result_digit
  );
endinterface

// File: rtl/inference_sequencer.sv
// Frame-level controller for the MNIST datapath: clears layer 1, feeds pixels,
// sweeps layer 2 over the hidden features and holds the argmax digit.
module inference_sequencer #(
  parameter int NUM_PIXELS = 784,
  parameter int NUM_L1     = 128,
  parameter int L1_DRAIN   = 2,
  parameter int L2_DRAIN   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  inference_sequencer_if.slave   bus,
  output logic                   l1_clr,
  output logic [7:0]             l1_pixel,
  output logic [9:0]             l1_addr,
  output logic [6:0]             l2_addr,
  output logic                   l2_en,
  output logic                   l2_feat_valid,
  input  logic [3:0]             digit_in,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FEED, S_L1_DRAIN, S_SWEEP, S_L2_DRAIN, S_CAPTURE, S_DONE
  } state_t;

  state_t      state, next_state;
  logic [9:0]  pix_cnt;
  logic [7:0]  drain_cnt;
  logic        beat, pix_last, feat_last, l1_drain_done, l2_drain_done, abort_now;

  always_comb begin
    beat          = (state == S_FEED) && bus.pix_valid;
    pix_last      = (pix_cnt == 10'(NUM_PIXELS - 1));
    feat_last     = (l2_addr == 7'(NUM_L1 - 1));
    l1_drain_done = (drain_cnt == 8'(L1_DRAIN - 1));
    l2_drain_done = (drain_cnt == 8'(L2_DRAIN - 1));
    abort_now     = abort && (state != S_IDLE);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start)             next_state = S_CLR;
      S_CLR:                             next_state = S_FEED;
      S_FEED:     if (beat && pix_last)  next_state = S_L1_DRAIN;
      S_L1_DRAIN: if (l1_drain_done)     next_state = S_SWEEP;
      S_SWEEP:    if (feat_last)         next_state = S_L2_DRAIN;
      S_L2_DRAIN: if (l2_drain_done)     next_state = S_CAPTURE;
      S_CAPTURE:                         next_state = S_DONE;
      S_DONE:     if (bus.result_ready)  next_state = S_IDLE;
      default:                           next_state = S_IDLE;
    endcase
    if (abort_now) next_state = S_IDLE;
  end

  // Status outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      bus.pix_ready    <= 1'b0;
      l1_clr           <= 1'b0;
      l2_en            <= 1'b0;
      l2_feat_valid    <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      state            <= next_state;
      busy             <= (next_state != S_IDLE);
      bus.pix_ready    <= (next_state == S_FEED);
      l1_clr           <= (next_state == S_CLR);
      l2_en            <= (next_state == S_SWEEP) || (next_state == S_L2_DRAIN) ||
                          (next_state == S_CAPTURE) || (next_state == S_DONE);
      l2_feat_valid    <= (next_state == S_SWEEP);
      bus.result_valid <= (next_state == S_DONE);
    end
  end

  // A stalled FEED cycle drives pixel 0 so layer 1 accumulates nothing extra.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt          <= '0;
      drain_cnt        <= '0;
      l1_pixel         <= '0;
      l1_addr          <= '0;
      l2_addr          <= '0;
      bus.result_digit <= '0;
      frame_count      <= '0;
    end else if (abort_now) begin
      pix_cnt   <= '0;
      drain_cnt <= '0;
      l1_pixel  <= '0;
      l1_addr   <= '0;
      l2_addr   <= '0;
    end else begin
      l1_pixel <= beat ? bus.pix_data : 8'd0;
      if (beat) begin
        l1_addr <= pix_cnt;
        pix_cnt <= pix_last ? 10'd0 : pix_cnt + 10'd1;
      end
      if ((state == S_L1_DRAIN) || (state == S_L2_DRAIN))
        drain_cnt <= (next_state != state) ? 8'd0 : drain_cnt + 8'd1;
      if ((state == S_SWEEP) && !feat_last)
        l2_addr <= l2_addr + 7'd1;
      else if ((state == S_L1_DRAIN) && (next_state == S_SWEEP))
        l2_addr <= '0;
      if (state == S_CAPTURE)
        bus.result_digit <= digit_in;
      if ((state == S_DONE) && bus.result_ready)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer: drivers queue expected beats/results,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_inference_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        l1_clr;
  logic [7:0]  l1_pixel;
  logic [9:0]  l1_addr;
  logic [6:0]  l2_addr;
  logic        l2_en, l2_feat_valid, busy;
  logic [15:0] frame_count;

  inference_sequencer_if bus();

  inference_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .l1_clr(l1_clr), .l1_pixel(l1_pixel), .l1_addr(l1_addr),
    .l2_addr(l2_addr), .l2_en(l2_en), .l2_feat_valid(l2_feat_valid),
    .digit_in(digit_in), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  digit;
    logic [15:0] fc;
    int          lat;
  } res_t;

  res_t        rq[$];
  logic [17:0] pq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] fc_model = 16'd0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no/unexpected event, expected event in bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_pix_ready"}, bus.pix_ready, 0);
    checkOutput({tag, "_l1_clr"}, l1_clr, 0);
    checkOutput({tag, "_l2_en"}, l2_en, 0);
    checkOutput({tag, "_l2_feat_valid"}, l2_feat_valid, 0);
    checkOutput({tag, "_result_valid"}, bus.result_valid, 0);
    checkOutput({tag, "_l1_pixel"}, l1_pixel, 0);
    checkOutput({tag, "_l1_addr"}, l1_addr, 0);
    checkOutput({tag, "_l2_addr"}, l2_addr, 0);
    checkOutput({tag, "_result_digit"}, bus.result_digit, 0);
    checkOutput({tag, "_frame_count"}, frame_count, 0);
  endtask

  task automatic applyStimulus(input logic [3:0] d);
    digit_in = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // pix_valid is raised already in CLR so the ignored-outside-FEED case is exercised.
  task automatic feedPixels(input int n, input bit gaps, output int gap_cnt);
    int i = 0;
    int k = 0;
    int guard = 0;
    gap_cnt = 0;
    while (i < n && guard < 4000) begin
      bus.pix_valid = !(gaps && (k % 3 == 2));
      bus.pix_data  = i[7:0];
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) begin
        pq.push_back({i[9:0], i[7:0]});
        i++;
      end else if (bus.pix_ready) begin
        gap_cnt++;
      end
      tick();
      k++;
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'd0;
    if (i < n) failNow("feed_timeout");
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) failNow("idle_timeout");
    tick();
  endtask

  task automatic runFrame(input logic [3:0] d, input bit gaps);
    int g;
    applyStimulus(d);
    feedPixels(784, gaps, g);
    fc_model++;
    rq.push_back('{d, fc_model, 918 + g});
    waitIdle(2000);
  endtask

  initial begin : monitor
    bit          beat_prev = 1'b0;
    bit          fc_pending = 1'b0;
    bit          seen = 1'b0;
    logic [17:0] ep;
    res_t        er;
    logic [15:0] exp_fc = 16'd0;
    int          start_cyc = 0;
    int          sweep_idx = 0;
    int          clr_cnt = 0;
    int          lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_prev  = 1'b0;
        fc_pending = 1'b0;
      end else begin
        if (fc_pending) begin
          checkOutput("frame_count", frame_count, exp_fc);
          fc_pending = 1'b0;
        end
        if (beat_prev) begin
          if (pq.size() == 0) failNow("unexpected_beat");
          else begin
            ep = pq.pop_front();
            checkOutput("l1_addr", l1_addr, ep[17:8]);
            checkOutput("l1_pixel", l1_pixel, ep[7:0]);
          end
        end else begin
          checkOutput("l1_pixel_gap", l1_pixel, 0);
        end
        beat_prev = bus.pix_valid && bus.pix_ready;
        if (start && !busy) begin
          start_cyc = cyc + 1;
          sweep_idx = 0;
          clr_cnt   = 0;
          seen      = 1'b0;
        end
        if (l1_clr) begin
          clr_cnt++;
          checkOutput("l1_clr_cycle", cyc - start_cyc, 0);
        end
        if (l2_feat_valid) begin
          checkOutput("l2_addr", l2_addr, sweep_idx);
          sweep_idx++;
        end
        if (bus.result_valid && !seen) begin
          seen = 1'b1;
          lat  = cyc - start_cyc;
        end
        if (bus.result_valid && bus.result_ready) begin
          if (rq.size() == 0) failNow("unexpected_result");
          else begin
            er = rq.pop_front();
            checkOutput("result_digit", bus.result_digit, er.digit);
            checkOutput("latency", lat, er.lat);
            checkOutput("sweep_cycles", sweep_idx, 128);
            checkOutput("l1_clr_pulses", clr_cnt, 1);
            exp_fc     = er.fc;
            fc_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    failNow("global_timeout");
    $fatal(1, "[TB] simulation did not finish in time");
  end

  initial begin : driver
    int g;
    int n;
    bus.pix_valid    = 1'b0;
    bus.pix_data     = 8'd0;
    bus.result_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    checkResetValues("reset");
    tick();

    runFrame(4'd7, 1'b0);
    runFrame(4'd2, 1'b1);

    // Held result: digit_in wanders and a start pulse arrives while DONE waits.
    bus.result_ready = 1'b0;
    applyStimulus(4'd3);
    feedPixels(784, 1'b0, g);
    fc_model++;
    rq.push_back('{4'd3, fc_model, 918});
    n = 0;
    @(negedge clk);
    while (!bus.result_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.result_valid) failNow("result_valid_timeout");
    tick();
    for (int c = 0; c < 50; c++) begin
      digit_in = 4'(c);
      start = (c >= 10 && c < 13);
      @(negedge clk);
      checkOutput("hold_result_valid", bus.result_valid, 1);
      checkOutput("hold_result_digit", bus.result_digit, 3);
      checkOutput("hold_l2_en", l2_en, 1);
      tick();
    end
    start = 1'b0;
    bus.result_ready = 1'b1;
    waitIdle(10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("ignored_start_busy", busy, 0);
      checkOutput("ignored_start_pix_ready", bus.pix_ready, 0);
    end
    tick();

    // Abort at pixel 400 discards the frame.
    applyStimulus(4'd5);
    feedPixels(400, 1'b0, g);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_pix_ready", bus.pix_ready, 0);
    checkOutput("abort_result_valid", bus.result_valid, 0);
    checkOutput("abort_frame_count", frame_count, fc_model);
    tick();
    runFrame(4'd5, 1'b0);

    // Reset in the middle of the layer-2 sweep.
    applyStimulus(4'd1);
    feedPixels(784, 1'b0, g);
    n = 0;
    @(negedge clk);
    while (!l2_feat_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!l2_feat_valid) failNow("sweep_timeout");
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("mid_sweep_reset");
    fc_model = 16'd0;
    tick();

    // Frame counter wrap from 65535.
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    fc_model = 16'hFFFF;
    tick();
    runFrame(4'd9, 1'b0);

    repeat (3) tick();
    checkOutput("pixel_queue_drained", pq.size(), 0);
    checkOutput("result_queue_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
